// File: rtl/ber_pkg.sv
// Shared constants and FSM encoding for the BER display formatter.
package ber_pkg;

    localparam int         BER_WIDTH   = 32;
    localparam int         BER_DIGITS  = 10;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FMT
    } ber_state_e;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get 3 added.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/ber_bcd_fmt.sv
// Error-count to packed BCD and blanked ASCII converter (shift-add-3).
// A one-entry pending slot absorbs samples that arrive mid-conversion.
module ber_bcd_fmt
    import ber_pkg::*;
#(
    parameter int WIDTH       = BER_WIDTH,
    parameter int DIGITS      = BER_DIGITS,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                valid_i,
    input  logic [WIDTH-1:0]    value_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [8*DIGITS-1:0] ascii_o,
    output logic                overrun_o
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [8*DIGITS-1:0] ASCII_RST =
        {{(DIGITS-1){ASCII_SPACE}}, ASCII_ZERO};

    ber_state_e          state;
    ber_state_e          state_nx;
    logic [SW-1:0]       sr;
    logic [CW-1:0]       cnt;
    logic                pend_full;
    logic [WIDTH-1:0]    pend_val;
    logic [WIDTH-1:0]    src;
    logic [BW-1:0]       bcd_adj;
    logic [8*DIGITS-1:0] ascii_nx;
    logic                start;
    logic                fmt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (valid_i || pend_full) state_nx = SHIFT;
            SHIFT:   if (cnt == LAST) state_nx = FMT;
            FMT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
        start  = (state == IDLE) && (valid_i || pend_full);
        fmt    = (state == FMT);
        src    = valid_i ? value_i : pend_val;
    end

    // Fresh input always beats a held sample; losing one is flagged.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_full <= 1'b0;
            pend_val  <= '0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= valid_i && pend_full;
            if (busy_o) begin
                if (valid_i) begin
                    pend_full <= 1'b1;
                    pend_val  <= value_i;
                end
            end else if (start) begin
                pend_full <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[WIDTH+4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr  <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= {{BW{1'b0}}, src};
            cnt <= '0;
        end else if (state == SHIFT) begin
            sr  <= {bcd_adj, sr[WIDTH-1:0]} << 1;
            cnt <= cnt + 1'b1;
        end
    end

    // Leading-zero scan from the most significant digit down.
    always_comb begin
        logic       lead;
        logic [3:0] d;
        lead     = BLANK_ZEROS;
        d        = 4'd0;
        ascii_nx = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = sr[WIDTH+4*i +: 4];
            if (d != 4'd0 || i == 0) lead = 1'b0;
            ascii_nx[8*i +: 8] = lead ? ASCII_SPACE
                                      : ASCII_ZERO + {4'h0, d};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_o <= 1'b0;
            bcd_o   <= '0;
            ascii_o <= ASCII_RST;
        end else begin
            valid_o <= fmt;
            if (fmt) begin
                bcd_o   <= sr[SW-1:WIDTH];
                ascii_o <= ascii_nx;
            end
        end
    end

endmodule

// File: tb/tb_ber_bcd_fmt.sv
// Scoreboard bench for ber_bcd_fmt, blanked and unblanked builds.
module tb_ber_bcd_fmt;

    logic        CLK;
    logic        RST;
    logic        valid_i;
    logic [31:0] value_i;
    logic        busy_o, valid_o, overrun_o;
    logic [39:0] bcd_o;
    logic [79:0] ascii_o;
    logic        busy0, valid0, ovr0;
    logic [39:0] bcd0;
    logic [79:0] ascii0;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int ovr_cnt = 0;
    int ovr_edge = -1;

    typedef struct {
        logic [39:0] bcd;
        logic [79:0] a1;
        logic [79:0] a0;
        int          edge_no;
    } exp_t;

    exp_t q[$];

    ber_bcd_fmt #(.WIDTH(32), .DIGITS(10), .BLANK_ZEROS(1'b1)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .valid_i   (valid_i),
        .value_i   (value_i),
        .busy_o    (busy_o),
        .valid_o   (valid_o),
        .bcd_o     (bcd_o),
        .ascii_o   (ascii_o),
        .overrun_o (overrun_o)
    );

    ber_bcd_fmt #(.WIDTH(32), .DIGITS(10), .BLANK_ZEROS(1'b0)) dut0 (
        .CLK       (CLK),
        .RST       (RST),
        .valid_i   (valid_i),
        .value_i   (value_i),
        .busy_o    (busy0),
        .valid_o   (valid0),
        .bcd_o     (bcd0),
        .ascii_o   (ascii0),
        .overrun_o (ovr0)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edges++;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)",
                     name, act, exp, edges);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic strobe(input logic [31:0] v, output int e0);
        valid_i = 1'b1;
        value_i = v;
        @(posedge CLK);
        #1;
        e0 = edges;
        valid_i = 1'b0;
    endtask

    task automatic push(input logic [39:0] b, input logic [79:0] a1,
                        input logic [79:0] a0, input int e);
        exp_t it;
        it.bcd = b;
        it.a1 = a1;
        it.a0 = a0;
        it.edge_no = e;
        q.push_back(it);
    endtask

    // Monitor: pops one expectation per output strobe.
    always @(negedge CLK) begin
        exp_t it;
        if (overrun_o) begin
            ovr_cnt++;
            ovr_edge = edges;
        end
        if (valid_o || valid0) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: bcd %h at edge %0d",
                         bcd_o, edges);
            end else begin
                it = q.pop_front();
                chk("valid_pair", 80'(valid0), 80'(valid_o));
                chk("bcd", 80'(bcd_o), 80'(it.bcd));
                chk("bcd_noblank", 80'(bcd0), 80'(it.bcd));
                chk("ascii_blank", ascii_o, it.a1);
                chk("ascii_noblank", ascii0, it.a0);
                chk("latency_edge", 80'(edges), 80'(it.edge_no));
                chk("busy_at_valid", 80'(busy_o), 80'(0));
            end
        end
    end

    initial begin
        int e, e2, o0, n;
        CLK = 1'b0;
        RST = 1'b1;
        valid_i = 1'b0;
        value_i = '0;
        #2 RST = 1'b0;
        #2;
        chk("rst_busy", 80'(busy_o), 80'(0));
        chk("rst_valid", 80'(valid_o), 80'(0));
        chk("rst_bcd", 80'(bcd_o), 80'(0));
        chk("rst_ascii", ascii_o, "         0");
        chk("rst_ascii_nb", ascii0, "         0");
        chk("rst_overrun", 80'(overrun_o), 80'(0));
        tick(2);
        RST = 1'b1;
        tick(2);

        strobe(32'd0, e);
        push(40'h0, "         0", "0000000000", e + 33);
        tick(2);
        chk("busy_during", 80'(busy_o), 80'(1));
        tick(40);

        o0 = ovr_cnt;
        strobe(32'hFFFF_FFFF, e);
        push(40'h4294967295, "4294967295", "4294967295", e + 33);
        tick(40);
        chk("no_ovr_max", 80'(ovr_cnt - o0), 80'(0));

        strobe(32'd1234, e);
        push(40'h0000001234, "      1234", "0000001234", e + 33);
        tick(40);

        o0 = ovr_cnt;
        strobe(32'd7, e);
        push(40'h7, "         7", "0000000007", e + 33);
        tick(9);
        strobe(32'd99, e2);
        push(40'h99, "        99", "0000000099", e + 67);
        tick(70);
        chk("no_ovr_b2b", 80'(ovr_cnt - o0), 80'(0));

        o0 = ovr_cnt;
        strobe(32'd1, e);
        push(40'h1, "         1", "0000000001", e + 33);
        tick(4);
        strobe(32'd2, e2);
        strobe(32'd3, e2);
        push(40'h3, "         3", "0000000003", e + 67);
        tick(70);
        chk("ovr_count", 80'(ovr_cnt - o0), 80'(1));
        chk("ovr_edge", 80'(ovr_edge), 80'(e + 6));

        strobe(32'd555, e);
        tick(2);
        strobe(32'd8, e2);
        tick(11);
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", 80'(busy_o), 80'(0));
        chk("mid_rst_valid", 80'(valid_o), 80'(0));
        chk("mid_rst_bcd", 80'(bcd_o), 80'(0));
        chk("mid_rst_ascii", ascii_o, "         0");
        chk("mid_rst_ovr", 80'(overrun_o), 80'(0));
        tick(3);
        RST = 1'b1;
        tick(3);
        strobe(32'd42, e);
        push(40'h42, "        42", "0000000042", e + 33);
        tick(40);

        n = 0;
        while (q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        chk("queue_drained", 80'(q.size()), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
